fir_sym_mc: RTL and testbench
=============================

Name: fir_sym_mc

Overview:
Parametrised multi-channel symmetric FIR filter; the successor to the fixed 22-tap IR/RED filters in the pulse-oximeter front end. One shared multiply-accumulate engine is time-multiplexed across NUM_CH per-channel delay lines, for example IR and RED sharing one instance. Coefficients reset from a parameter table and can be rewritten at runtime. A valid/ready input and a one-cycle output strobe replace the old free-running enable rotation.

Parameters:
DATA_W, 8, unsigned sample width
COEFF_W, 8, unsigned coefficient width
TAPS, 22, filter length; even, >=4; HALF = TAPS/2 unique coefficients
NUM_CH, 2, independent channels, >=1; CH_W = max(1, clog2(NUM_CH))
OUT_W, 20, output width
OUT_SHIFT, 0, right shift applied to accumulator before saturation
COEFF_INIT, {2,10,16,28,43,60,78,95,111,122,128}, HALF x COEFF_W packed reset table, element k = coeff[k]

Ports:
CLK_Filter  in  1  filter clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample offered
in_ready  out  1  block can accept a sample
in_ch  in  CH_W  channel of offered sample
in_data  in  DATA_W  sample value
flush  in  1  synchronous clear of all history and any computation in flight
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(HALF)  coefficient index
coef_data  in  COEFF_W  coefficient value
out_valid  out  1  one-cycle result strobe
out_ch  out  CH_W  channel of result
out_data  out  OUT_W  filtered value
out_sat  out  1  out_data was clipped

Behaviour:
- Reset (async, rst_n=0):
  - all delay lines = 0; coefficients = COEFF_INIT; FSM = IDLE; accumulator and counter = 0.
  - out_valid=0, out_ch=0, out_data=0, out_sat=0, in_ready=1 (combinational from IDLE once rst_n=1).
  - Reset mid-computation abandons the computation; no out_valid is produced.
- FSM states: IDLE, MAC, OUT. in_ready = (state==IDLE).
- IDLE:
  - On in_valid&in_ready with flush=0, channel c=in_ch shifts: x_c[i+1]<=x_c[i] for i=0..TAPS-2, x_c[0]<=in_data, oldest sample discarded.
  - Latch c, clear accumulator, counter k=0, go to MAC.
  - in_ch>=NUM_CH: sample dropped, stay IDLE, no output.
- MAC: each cycle acc += coeff[k]*(x_c[k]+x_c[TAPS-1-k]), using post-shift history; k++. After k=HALF-1, go to OUT.
- Arithmetic:
  - unsigned throughout.
  - pair sum DATA_W+1 bits; ACC_W = DATA_W+1+COEFF_W+clog2(HALF) (21 for defaults); no internal overflow possible.
- OUT: for one cycle, out_valid=1, out_ch=c, out_data=min(acc>>OUT_SHIFT, 2^OUT_W-1), out_sat=1 iff clipped; then IDLE.
- out_data, out_ch and out_sat hold their values between strobes.
- Latency: sample accepted at edge t; out_valid high in the cycle after edge t+HALF+1. Throughput is one sample per HALF+2 cycles (13 for defaults).
- Other channels' histories are untouched by any operation on channel c.
- flush=1 (any state):
  - next edge zeroes all delay lines, state=IDLE; any in-flight result is discarded and gives no out_valid.
  - flush wins over a simultaneous in_valid (sample dropped); coefficients are unaffected.
- Coefficient writes:
  - coef_we applied only when state==IDLE and coef_addr<HALF; otherwise ignored.
  - A write in the same IDLE cycle as a sample accept takes effect before that sample's MAC.
- Taps are symmetric by construction: coeff[k] applies to taps k and TAPS-1-k.

Test Plan:
- Impulse: ch0 sample 1 then 21 zeros, defaults -> out_data sequence 2,10,16,28,43,60,78,95,111,122,128,128,122,...,10,2, all out_ch=0, out_sat=0.
- Step: 22 samples of 255 on ch0 -> 22nd result = 255*1386 = 353430, out_sat=0; each out_valid 13 cycles after its accept; in_ready low 12 cycles.
- Channel isolation: interleave ch0=255 and ch1=0 for 22 samples each -> ch1 results all 0; ch0 final result 353430.
- Saturation: OUT_W=16, OUT_SHIFT=0, step 255 -> final out_data=65535, out_sat=1. Repeat with OUT_SHIFT=4 -> 22089, out_sat=0.
- Coefficient write: in IDLE write addr0=100, addr10=0, then impulse -> first result 100, eleventh result 0. A write during MAC is ignored.
- Flush/reset mid-MAC: flush at k=5 -> no out_valid, in_ready=1 next cycle, next sample 7 gives result 7*2=14. Asserting rst_n=0 mid-MAC gives all outputs 0 immediately.

Source files
------------

// File: rtl/fir_sym_mc.sv
// Multi-channel symmetric FIR: one shared multiply-accumulate engine walks the
// folded tap pairs of whichever channel's history just received a sample.
//
// state | meaning
// IDLE  | ready for a sample or a coefficient write
// MAC   | one folded tap pair accumulated per cycle, k = 0..HALF-1
// OUT   | scale/clip the accumulator and present it as a one-cycle strobe
module fir_sym_mc #(
  parameter int DATA_W    = 8,
  parameter int COEFF_W   = 8,
  parameter int TAPS      = 22,
  parameter int NUM_CH    = 2,
  parameter int OUT_W     = 20,
  parameter int OUT_SHIFT = 0,
  localparam int HALF     = TAPS / 2,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CA_W     = $clog2(HALF),
  parameter logic [HALF*COEFF_W-1:0] COEFF_INIT =
    {8'd128, 8'd122, 8'd111, 8'd95, 8'd78, 8'd60, 8'd43, 8'd28, 8'd16, 8'd10, 8'd2}
) (
  input  logic               CLK_Filter,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               flush,
  input  logic               coef_we,
  input  logic [CA_W-1:0]    coef_addr,
  input  logic [COEFF_W-1:0] coef_data,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_sat
);

  localparam int PAIR_W = DATA_W + 1;
  localparam int PROD_W = PAIR_W + COEFF_W;
  localparam int ACC_W  = PAIR_W + COEFF_W + $clog2(HALF);
  localparam int CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CA_W-1:0]     k_q, k_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [COEFF_W-1:0]  coef_q [HALF];
  logic [COEFF_W-1:0]  coef_d [HALF];
  logic [DATA_W-1:0]   hist_q [NUM_CH][TAPS];
  logic [DATA_W-1:0]   hist_d [NUM_CH][TAPS];
  logic                out_valid_q, out_valid_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_sat_q, out_sat_d;

  logic [PAIR_W-1:0]   pair;
  logic [PROD_W-1:0]   prod;
  logic [CMP_W-1:0]    scaled;
  logic [CMP_W-1:0]    out_max;
  logic                clip;
  logic                coef_ok;
  logic                ch_ok;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Folding the symmetric pair before the multiply halves the MAC cycles.
  assign pair    = {1'b0, hist_q[ch_q][k_q]} + {1'b0, hist_q[ch_q][TAPS-1-int'(k_q)]};
  assign prod    = {{COEFF_W{1'b0}}, pair} * {{PAIR_W{1'b0}}, coef_q[k_q]};
  assign scaled  = CMP_W'(acc_q >> OUT_SHIFT);
  assign out_max = CMP_W'({OUT_W{1'b1}});
  assign clip    = (scaled > out_max);
  assign coef_ok = ({1'b0, coef_addr} < (CA_W+1)'(HALF));
  assign ch_ok   = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    k_d         = k_q;
    acc_d       = acc_q;
    coef_d      = coef_q;
    hist_d      = hist_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    // A write landing with a sample accept is visible to that sample's MAC.
    if (state_q == S_IDLE && coef_we && coef_ok) begin
      coef_d[coef_addr] = coef_data;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush && ch_ok) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == in_ch) begin
              for (int i = TAPS - 1; i > 0; i--) begin
                hist_d[c][i] = hist_q[c][i-1];
              end
              hist_d[c][0] = in_data;
            end
          end
          ch_d    = in_ch;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{(ACC_W-PROD_W){1'b0}}, prod};
        if (k_q == CA_W'(HALF - 1)) begin
          state_d = S_OUT;
        end else begin
          k_d = k_q + CA_W'(1);
        end
      end
      S_OUT: begin
        out_valid_d = 1'b1;
        out_ch_d    = ch_q;
        out_sat_d   = clip;
        out_data_d  = clip ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < TAPS; i++) begin
          hist_d[c][i] = '0;
        end
      end
      state_d     = S_IDLE;
      acc_d       = '0;
      k_d         = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int k = 0; k < HALF; k++) begin
        coef_q[k] <= COEFF_INIT[k*COEFF_W +: COEFF_W];
      end
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < TAPS; i++) begin
          hist_q[c][i] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      coef_q      <= coef_d;
      hist_q      <= hist_d;
    end
  end

endmodule

// File: tb/tb_fir_sym_mc.sv
// Directed bench for fir_sym_mc: default instance plus two 16-bit-output
// instances (shift 0 and shift 4) sharing the same stimulus.
module tb_fir_sym_mc;

  logic        CLK_Filter = 1'b0;
  logic        rst_n      = 1'b1;
  logic        in_valid   = 1'b0;
  logic        in_ch      = 1'b0;
  logic [7:0]  in_data    = '0;
  logic        flush      = 1'b0;
  logic        coef_we    = 1'b0;
  logic [3:0]  coef_addr  = '0;
  logic [7:0]  coef_data  = '0;

  logic        in_ready, out_valid, out_ch, out_sat;
  logic [19:0] out_data;
  logic        in_ready_a, out_valid_a, out_ch_a, out_sat_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_ch_b, out_sat_b;
  logic [15:0] out_data_b;

  fir_sym_mc u_dut (
    .CLK_Filter(CLK_Filter), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_data(in_data), .flush(flush), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid),
    .out_ch(out_ch), .out_data(out_data), .out_sat(out_sat));

  fir_sym_mc #(.OUT_W(16), .OUT_SHIFT(0)) u_s0 (
    .CLK_Filter(CLK_Filter), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_ch(in_ch), .in_data(in_data), .flush(flush), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid_a),
    .out_ch(out_ch_a), .out_data(out_data_a), .out_sat(out_sat_a));

  fir_sym_mc #(.OUT_W(16), .OUT_SHIFT(4)) u_s4 (
    .CLK_Filter(CLK_Filter), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ch(in_ch), .in_data(in_data), .flush(flush), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid_b),
    .out_ch(out_ch_b), .out_data(out_data_b), .out_sat(out_sat_b));

  always #5 CLK_Filter = ~CLK_Filter;

  int n_cmp = 0;
  int n_err = 0;
  int coef_tab [11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};

  logic [19:0] r_data;
  logic        r_ch, r_sat;
  logic [15:0] ra_data, rb_data;
  logic        ra_sat, rb_sat;
  int          r_lat, r_low;
  bit          r_ok;

  function automatic int h_of(input int n);
    return (n < 11) ? coef_tab[n] : coef_tab[21 - n];
  endfunction

  task automatic accept(input logic ch, input logic [7:0] d);
    @(negedge CLK_Filter);
    in_valid = 1'b1; in_ch = ch; in_data = d;
    @(posedge CLK_Filter);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out();
    r_ok = 0; r_lat = 0; r_low = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK_Filter);
      if (!in_ready) r_low++;
      if (out_valid) begin
        r_ok = 1; r_lat = n;
        r_data = out_data; r_ch = out_ch; r_sat = out_sat;
        ra_data = out_data_a; ra_sat = out_sat_a;
        rb_data = out_data_b; rb_sat = out_sat_b;
        break;
      end
    end
  endtask

  task automatic send(input logic ch, input logic [7:0] d);
    accept(ch, d);
    wait_out();
  endtask

  task automatic do_flush();
    @(negedge CLK_Filter);
    flush = 1'b1;
    @(posedge CLK_Filter);
    #1 flush = 1'b0;
  endtask

  task automatic coef_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK_Filter);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge CLK_Filter);
    #1 coef_we = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 20'd0) begin n_err++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_cmp++; if (out_ch !== 1'b0) begin n_err++; $display("FAIL reset_out_ch got %b want 0", out_ch); end
    n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
    @(negedge CLK_Filter);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_impulse();
    do_flush();
    for (int n = 0; n < 22; n++) begin
      send(1'b0, (n == 0) ? 8'd1 : 8'd0);
      n_cmp++;
      if (!r_ok) begin
        n_err++; $display("FAIL impulse_timeout n=%0d no out_valid within 20 cycles", n);
      end else if (r_data !== 20'(h_of(n))) begin
        n_err++; $display("FAIL impulse_data n=%0d got %0d want %0d", n, r_data, h_of(n));
      end
      n_cmp++;
      if ({r_ch, r_sat} !== 2'b00) begin
        n_err++; $display("FAIL impulse_ch_sat n=%0d got ch=%b sat=%b want 0 0", n, r_ch, r_sat);
      end
    end
  endtask

  task automatic test_step();
    int exp_acc;
    exp_acc = 0;
    do_flush();
    for (int n = 0; n < 22; n++) begin
      exp_acc += 255 * h_of(n);
      send(1'b0, 8'd255);
      n_cmp++;
      if (!r_ok || r_data !== 20'(exp_acc)) begin
        n_err++; $display("FAIL step_data n=%0d ok=%0d got %0d want %0d", n, r_ok, r_data, exp_acc);
      end
      n_cmp++;
      if (r_lat != 13) begin n_err++; $display("FAIL step_latency n=%0d got %0d want 13", n, r_lat); end
      n_cmp++;
      if (r_low != 12) begin n_err++; $display("FAIL step_ready_low n=%0d got %0d want 12", n, r_low); end
    end
    n_cmp++; if (r_data !== 20'd353430 || r_sat !== 1'b0) begin
      n_err++; $display("FAIL step_final got %0d sat=%b want 353430 sat=0", r_data, r_sat); end
    n_cmp++; if (ra_data !== 16'd65535 || ra_sat !== 1'b1) begin
      n_err++; $display("FAIL sat_shift0 got %0d sat=%b want 65535 sat=1", ra_data, ra_sat); end
    n_cmp++; if (rb_data !== 16'd22089 || rb_sat !== 1'b0) begin
      n_err++; $display("FAIL sat_shift4 got %0d sat=%b want 22089 sat=0", rb_data, rb_sat); end
  endtask

  task automatic test_channel_isolation();
    logic [19:0] ch0_last;
    logic        ch0_ch;
    ch0_last = '0; ch0_ch = 1'b1;
    do_flush();
    for (int i = 0; i < 22; i++) begin
      send(1'b0, 8'd255);
      ch0_last = r_ok ? r_data : 20'hFFFFF;
      ch0_ch   = r_ch;
      send(1'b1, 8'd0);
      n_cmp++;
      if (!r_ok || r_data !== 20'd0 || r_ch !== 1'b1) begin
        n_err++; $display("FAIL chan_ch1 i=%0d ok=%0d got %0d ch=%b want 0 ch=1", i, r_ok, r_data, r_ch);
      end
    end
    n_cmp++;
    if (ch0_last !== 20'd353430 || ch0_ch !== 1'b0) begin
      n_err++; $display("FAIL chan_ch0_final got %0d ch=%b want 353430 ch=0", ch0_last, ch0_ch);
    end
  endtask

  task automatic test_coef_write();
    do_flush();
    coef_wr(4'd0, 8'd100);
    coef_wr(4'd10, 8'd0);
    accept(1'b0, 8'd1);
    repeat (2) @(negedge CLK_Filter);
    coef_wr(4'd1, 8'd200);
    wait_out();
    n_cmp++;
    if (!r_ok || r_data !== 20'd100) begin
      n_err++; $display("FAIL coef_first ok=%0d got %0d want 100", r_ok, r_data); end
    for (int n = 1; n < 22; n++) begin
      send(1'b0, 8'd0);
      if (n == 1) begin
        n_cmp++; if (!r_ok || r_data !== 20'd10) begin
          n_err++; $display("FAIL coef_mac_write_ignored got %0d want 10", r_data); end
      end else if (n == 10 || n == 11) begin
        n_cmp++; if (!r_ok || r_data !== 20'd0) begin
          n_err++; $display("FAIL coef_addr10 n=%0d got %0d want 0", n, r_data); end
      end else if (n == 21) begin
        n_cmp++; if (!r_ok || r_data !== 20'd100) begin
          n_err++; $display("FAIL coef_last got %0d want 100", r_data); end
      end
    end
    coef_wr(4'd10, 8'd128);
    do_flush();
    @(negedge CLK_Filter);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd5;
    in_valid = 1'b1; in_ch = 1'b0; in_data = 8'd1;
    @(posedge CLK_Filter);
    #1 begin coef_we = 1'b0; in_valid = 1'b0; end
    wait_out();
    n_cmp++;
    if (!r_ok || r_data !== 20'd5) begin
      n_err++; $display("FAIL coef_same_cycle ok=%0d got %0d want 5", r_ok, r_data); end
    coef_wr(4'd0, 8'd2);
  endtask

  task automatic test_flush_mid_mac();
    int seen;
    do_flush();
    accept(1'b0, 8'd200);
    repeat (5) @(negedge CLK_Filter);
    do_flush();
    @(negedge CLK_Filter);
    n_cmp++; if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    seen = 0;
    repeat (20) begin @(negedge CLK_Filter); if (out_valid) seen++; end
    n_cmp++; if (seen != 0) begin
      n_err++; $display("FAIL flush_no_output got %0d strobes want 0", seen); end
    send(1'b0, 8'd7);
    n_cmp++; if (!r_ok || r_data !== 20'd14) begin
      n_err++; $display("FAIL flush_next ok=%0d got %0d want 14", r_ok, r_data); end
  endtask

  task automatic test_reset_mid_mac();
    int seen;
    accept(1'b1, 8'd9);
    repeat (4) @(negedge CLK_Filter);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_data !== 20'd0) begin n_err++; $display("FAIL rst_mid_data got %0d want 0", out_data); end
    n_cmp++; if (out_valid !== 1'b0 || out_ch !== 1'b0 || out_sat !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_flags got v=%b ch=%b sat=%b want 0 0 0", out_valid, out_ch, out_sat); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    @(negedge CLK_Filter);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge CLK_Filter); if (out_valid) seen++; end
    n_cmp++; if (seen != 0) begin
      n_err++; $display("FAIL rst_mid_no_output got %0d strobes want 0", seen); end
    send(1'b0, 8'd3);
    n_cmp++; if (!r_ok || r_data !== 20'd6) begin
      n_err++; $display("FAIL rst_mid_next ok=%0d got %0d want 6", r_ok, r_data); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_channel_isolation();
    test_coef_write();
    test_flush_mid_mac();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
